// File: rtl/alu_seq16_if.sv
// ---------------------------------------------------------------------------
// alu_seq16_pkg / alu_seq16_if
// Shared types and the bundled command, result and ALU-drive signals of the
// 16-bit arithmetic sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_seq16_pkg;

  // Flag nibble in SM83 order {Z,N,H,C}
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  // Operations of the shared 8-bit ALU used by the sequencer
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3
  } alu_op_t;

  localparam logic [1:0] OP_ADD16  = 2'd0;
  localparam logic [1:0] OP_ADDSPE = 2'd1;
  localparam logic [1:0] OP_INC16  = 2'd2;
  localparam logic [1:0] OP_DEC16  = 2'd3;

endpackage

interface alu_seq16_if;
  import alu_seq16_pkg::*;

  // Command port from the CPU control unit
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] opa;
  logic [15:0] opb;
  flags_t      flags_in;

  // Result port
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  flags_t      flags_out;

  // Drive toward / response from the shared 8-bit ALU
  logic        alu_en;
  alu_op_t     alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  flags_t      alu_flags;
  logic [7:0]  alu_res;
  flags_t      alu_flags_out;

  // The sequencer: target of the command port, initiator toward the ALU
  modport slave (
    input  cmd_valid, cmd_op, opa, opb, flags_in, out_ready,
    input  alu_res, alu_flags_out,
    output cmd_ready, out_valid, res, flags_out,
    output alu_en, alu_op, alu_a, alu_b, alu_flags
  );

  // The surroundings: control unit plus the ALU itself
  modport master (
    output cmd_valid, cmd_op, opa, opb, flags_in, out_ready,
    output alu_res, alu_flags_out,
    input  cmd_ready, out_valid, res, flags_out,
    input  alu_en, alu_op, alu_a, alu_b, alu_flags
  );

endinterface

`default_nettype wire

// File: rtl/alu_seq16.sv
// ---------------------------------------------------------------------------
// alu_seq16
// Runs SM83 16-bit ADD HL,rr / ADD SP,e8 / INC rr / DEC rr as two byte passes
// (low then high) through the shared 8-bit ALU, carry chained in a register.
// Optional macro ALU_SEQ16_FAST_INCDEC_EN: INC16/DEC16 computed internally in
// the acceptance cycle, skipping the ALU passes.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq16
  import alu_seq16_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   reset,
  alu_seq16_if.slave  bus
);

`ifdef ALU_SEQ16_FAST_INCDEC_EN
  localparam logic c_FAST_INCDEC = 1'b1;
`else
  localparam logic c_FAST_INCDEC = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_op;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  flags_t      r_flags_l;
  logic        r_h_lo;
  logic        r_c_lo;
  logic [15:0] r_res;
  flags_t      r_flags_out;

  logic        w_accept;
  logic        w_is_incdec;
  logic [15:0] w_incdec;

  logic        w_alu_en;
  alu_op_t     w_alu_op;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  flags_t      w_alu_flags;

  // Z and N from the ALU never influence a 16-bit result
  logic        w_unused;
  assign w_unused = &{1'b0, bus.alu_flags_out.z, bus.alu_flags_out.n};

  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid && !reset;
  assign w_is_incdec = (bus.cmd_op == OP_INC16) || (bus.cmd_op == OP_DEC16);
  assign w_incdec    = (bus.cmd_op == OP_DEC16) ? (bus.opa - 16'd1) : (bus.opa + 16'd1);

  // Next-state selection and ALU drive; the ALU sees zeros outside LO/HI
  always_comb begin
    w_state_nxt = r_state;
    w_alu_en    = 1'b0;
    w_alu_op    = ALU_ADD;
    w_alu_a     = 8'h00;
    w_alu_b     = 8'h00;
    w_alu_flags = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (c_FAST_INCDEC && w_is_incdec) ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        w_alu_en    = 1'b1;
        w_alu_a     = r_opa[7:0];
        w_alu_flags = r_flags_l;
        case (r_op)
          OP_ADD16:  w_alu_b = r_opb[7:0];
          OP_ADDSPE: w_alu_b = r_opb[7:0];
          OP_INC16:  w_alu_b = 8'h01;
          default: begin
            w_alu_op = ALU_SUB;
            w_alu_b  = 8'h01;
          end
        endcase
        w_state_nxt = S_HI;
      end
      S_HI: begin
        w_alu_en    = 1'b1;
        w_alu_a     = r_opa[15:8];
        w_alu_flags = '{z: r_flags_l.z, n: r_flags_l.n, h: r_flags_l.h, c: r_c_lo};
        case (r_op)
          OP_ADD16: begin
            w_alu_op = ALU_ADC;
            w_alu_b  = r_opb[15:8];
          end
          OP_ADDSPE: begin
            w_alu_op = ALU_ADC;
            w_alu_b  = {8{r_opb[7]}};   // sign extension of e8
          end
          OP_INC16:  w_alu_op = ALU_ADC;
          default:   w_alu_op = ALU_SBC; // C carries the low-byte borrow
        endcase
        w_state_nxt = S_DONE;
      end
      default: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // State register, command latch and per-pass result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_opa       <= 16'h0000;
      r_opb       <= 16'h0000;
      r_flags_l   <= '0;
      r_h_lo      <= 1'b0;
      r_c_lo      <= 1'b0;
      r_res       <= 16'h0000;
      r_flags_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= bus.cmd_op;
            r_opa     <= bus.opa;
            r_opb     <= bus.opb;
            r_flags_l <= bus.flags_in;
            if (c_FAST_INCDEC && w_is_incdec) begin
              r_res       <= w_incdec;
              r_flags_out <= bus.flags_in;
            end
          end
        end
        S_LO: begin
          r_res[7:0] <= bus.alu_res;
          r_h_lo     <= bus.alu_flags_out.h;
          r_c_lo     <= bus.alu_flags_out.c;
        end
        S_HI: begin
          r_res[15:8] <= bus.alu_res;
          case (r_op)
            OP_ADD16:  r_flags_out <= '{z: r_flags_l.z, n: 1'b0,
                                        h: bus.alu_flags_out.h, c: bus.alu_flags_out.c};
            OP_ADDSPE: r_flags_out <= '{z: 1'b0, n: 1'b0, h: r_h_lo, c: r_c_lo};
            default:   r_flags_out <= r_flags_l;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE) && !reset;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.res       = r_res;
  assign bus.flags_out = r_flags_out;
  assign bus.alu_en    = w_alu_en;
  assign bus.alu_op    = w_alu_op;
  assign bus.alu_a     = w_alu_a;
  assign bus.alu_b     = w_alu_b;
  assign bus.alu_flags = w_alu_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq16.sv
// ---------------------------------------------------------------------------
// tb_alu_seq16
// Directed self-checking bench for alu_seq16 with a behavioural 8-bit ALU.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq16;
  import alu_seq16_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_seq16_if bus ();

  alu_seq16 u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_SEQ16_FAST_INCDEC_EN
  localparam int c_ID_LAT = 1;
  localparam int c_ID_EN  = 0;
`else
  localparam int c_ID_LAT = 3;
  localparam int c_ID_EN  = 2;
`endif

  // Behavioural 8-bit ALU answering the sequencer combinationally
  logic [8:0] m_s;
  logic [4:0] m_h;
  logic       m_ci;
  always_comb begin
    m_s  = 9'd0;
    m_h  = 5'd0;
    m_ci = 1'b0;
    bus.alu_res       = 8'h00;
    bus.alu_flags_out = '0;
    if (bus.alu_en) begin
      m_ci = ((bus.alu_op == ALU_ADC) || (bus.alu_op == ALU_SBC)) ? bus.alu_flags.c : 1'b0;
      if ((bus.alu_op == ALU_ADD) || (bus.alu_op == ALU_ADC)) begin
        m_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, m_ci};
        m_h = {1'b0, bus.alu_a[3:0]} + {1'b0, bus.alu_b[3:0]} + {4'd0, m_ci};
        bus.alu_flags_out.n = 1'b0;
      end else begin
        m_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, m_ci};
        m_h = {1'b0, bus.alu_a[3:0]} - {1'b0, bus.alu_b[3:0]} - {4'd0, m_ci};
        bus.alu_flags_out.n = 1'b1;
      end
      bus.alu_res         = m_s[7:0];
      bus.alu_flags_out.z = (m_s[7:0] == 8'h00);
      bus.alu_flags_out.h = m_h[4];
      bus.alu_flags_out.c = m_s[8];
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command, then scramble inputs and count cycles up to out_valid
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, output int lat, output int en);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.opa       = a;
    bus.opb       = b;
    bus.flags_in  = f;
    check("cmd_ready_idle", 16'(bus.cmd_ready), 16'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.opa       = 16'hA5A5;
    bus.opb       = 16'h5A5A;
    bus.flags_in  = 4'h5;
    lat = 1;
    en  = 0;
    while (!bus.out_valid && lat < 10) begin
      en += int'(bus.alu_en);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 16'(bus.out_valid), 16'd0);
    check({tag, "_ready_back"}, 16'(bus.cmd_ready), 16'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f, input logic [15:0] exp_res,
                        input logic [3:0] exp_f, input int exp_lat, input int exp_en);
    int lat;
    int en;
    issue(op, a, b, f, lat, en);
    check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check({tag, "_alu_en_cycles"}, 16'(en), 16'(exp_en));
    check({tag, "_res"}, bus.res, exp_res);
    check({tag, "_flags"}, 16'(bus.flags_out), 16'(exp_f));
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int en;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.opa       = 16'h0000;
    bus.opb       = 16'h0000;
    bus.flags_in  = 4'h0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 16'(bus.cmd_ready), 16'd0);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_res", bus.res, 16'h0000);
    check("rst_flags", 16'(bus.flags_out), 16'h0000);
    check("rst_alu_en", 16'(bus.alu_en), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    check("idle_alu_b", 16'(bus.alu_b), 16'd0);

    run_op("add16_h", OP_ADD16, 16'h0FFF, 16'h0001, 4'hD, 16'h1000, 4'hA, 3, 2);
    run_op("add16_wrap", OP_ADD16, 16'hFFFF, 16'h0001, 4'h7, 16'h0000, 4'h3, 3, 2);
    run_op("addspe_pos", OP_ADDSPE, 16'hFFF8, 16'h0008, 4'hF, 16'h0000, 4'h3, 3, 2);
    run_op("addspe_neg", OP_ADDSPE, 16'h0000, 16'hABFF, 4'hF, 16'hFFFF, 4'h0, 3, 2);
    run_op("dec16_wrap", OP_DEC16, 16'h0000, 16'h1234, 4'hF, 16'hFFFF, 4'hF, c_ID_LAT, c_ID_EN);
    run_op("inc16_byte", OP_INC16, 16'h00FF, 16'h0000, 4'h0, 16'h0100, 4'h0, c_ID_LAT, c_ID_EN);
    run_op("inc16_wrap", OP_INC16, 16'hFFFF, 16'hFFFF, 4'h9, 16'h0000, 4'h9, c_ID_LAT, c_ID_EN);

    // Backpressure: result held, new commands ignored while in DONE
    issue(OP_ADD16, 16'h1234, 16'h0001, 4'h0, lat, en);
    check("bp_lat", 16'(lat), 16'd3);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = (i % 2 == 0);
      bus.cmd_op    = OP_INC16;
      bus.opa       = 16'h7777;
      @(negedge clk);
      check("bp_out_valid", 16'(bus.out_valid), 16'd1);
      check("bp_res", bus.res, 16'h1235);
      check("bp_flags", 16'(bus.flags_out), 16'h0000);
      check("bp_cmd_ready", 16'(bus.cmd_ready), 16'd0);
    end
    bus.cmd_valid = 1'b0;
    handshake("bp");
    @(negedge clk);
    check("bp_no_spurious", 16'(bus.out_valid), 16'd0);

    // Reset while in HI aborts the operation
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD16;
    bus.opa       = 16'h0FFF;
    bus.opb       = 16'h0001;
    bus.flags_in  = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("hi_alu_en", 16'(bus.alu_en), 16'd1);
    check("hi_alu_a", 16'(bus.alu_a), 16'h000F);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 16'(bus.out_valid), 16'd0);
    check("abort_alu_en", 16'(bus.alu_en), 16'd0);
    check("abort_res", bus.res, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", 16'(bus.cmd_ready), 16'd1);
    check("abort_no_valid", 16'(bus.out_valid), 16'd0);
    run_op("post_rst_add", OP_ADD16, 16'h1234, 16'h1111, 4'h0, 16'h2345, 4'h0, 3, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
